// File: rtl/sprite_loader.sv
// ---------------------------------------------------------------------------
// sprite_loader
//
// Purpose:
//   Turns a framed byte stream (typically from the UART receiver) into write
//   transactions for the sprite palette RAM (24-bit {R,G,B}) and the indexed
//   image RAM (8-bit palette index). A packet is:
//     SYNC_BYTE, 256 x {R,G,B}, WIDTH*HEIGHT pixel indices, XOR checksum.
//   Everything runs in the pixel clock domain, one byte per cycle sustained.
//
// Ports:
//   pixel_clk_in      sole clock, rising edge
//   rst_n_in          asynchronous active-low reset
//   start_in          arms a load, only looked at while idle
//   byte_in           stream data
//   byte_valid_in     byte_in is valid
//   byte_ready_out    block accepts a byte this cycle (any state but idle)
//   palette_we_out    palette RAM write strobe (one cycle per entry)
//   palette_addr_out  palette entry index
//   palette_data_out  palette entry {R,G,B}
//   image_we_out      image RAM write strobe (one cycle per pixel)
//   image_addr_out    raster pixel address
//   image_data_out    pixel palette index
//   busy_out          a load is in progress
//   done_out          one-cycle pulse after the checksum byte is taken
//   error_out         checksum of the last load did not match
// ---------------------------------------------------------------------------
module sprite_loader #(
  parameter int          WIDTH     = 256,
  parameter int          HEIGHT    = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  localparam int         NPIX      = WIDTH * HEIGHT,
  localparam int         AW        = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic          pixel_clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid_in,
  output logic          byte_ready_out,
  output logic          palette_we_out,
  output logic [7:0]    palette_addr_out,
  output logic [23:0]   palette_data_out,
  output logic          image_we_out,
  output logic [AW-1:0] image_addr_out,
  output logic [7:0]    image_data_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          error_out
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PAL,
    IMG,
    CHECK
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    byte_idx;
  logic [7:0]    entry_cnt;
  logic [AW-1:0] pix_cnt;
  logic [7:0]    red_byte;
  logic [7:0]    green_byte;
  logic [7:0]    checksum;
  logic          accept;

  // Ready and busy come straight from the registered state, so there is no
  // combinational path from byte_valid_in back to the source.
  assign byte_ready_out = (state != IDLE);
  assign busy_out       = (state != IDLE);
  assign accept         = byte_valid_in && byte_ready_out;

  // State register. Reset drops any partially received packet; whatever has
  // already been written into the RAMs is simply left there.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. Every transition out of a data state happens on the
  // edge that accepts the terminal byte, so the stream never stalls between
  // palette, image and checksum phases.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_next = SYNC;
        end
      end
      SYNC: begin
        if (accept && byte_in == SYNC_BYTE) begin
          state_next = PAL;
        end
      end
      PAL: begin
        if (accept && byte_idx == 2'd2 && entry_cnt == 8'd255) begin
          state_next = IMG;
        end
      end
      IMG: begin
        if (accept && pix_cnt == AW'(NPIX - 1)) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: counters, running checksum and the registered write ports.
  // Strobes and done default low each cycle so they are single-cycle pulses;
  // address/data registers hold their last value between writes.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      byte_idx         <= 2'd0;
      entry_cnt        <= 8'd0;
      pix_cnt          <= '0;
      red_byte         <= 8'd0;
      green_byte       <= 8'd0;
      checksum         <= 8'd0;
      palette_we_out   <= 1'b0;
      palette_addr_out <= 8'd0;
      palette_data_out <= 24'd0;
      image_we_out     <= 1'b0;
      image_addr_out   <= '0;
      image_data_out   <= 8'd0;
      done_out         <= 1'b0;
      error_out        <= 1'b0;
    end else begin
      palette_we_out <= 1'b0;
      image_we_out   <= 1'b0;
      done_out       <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            byte_idx  <= 2'd0;
            entry_cnt <= 8'd0;
            pix_cnt   <= '0;
            checksum  <= 8'd0;
            error_out <= 1'b0;
          end
        end
        PAL: begin
          if (accept) begin
            checksum <= checksum ^ byte_in;
            case (byte_idx)
              2'd0: begin
                red_byte <= byte_in;
                byte_idx <= 2'd1;
              end
              2'd1: begin
                green_byte <= byte_in;
                byte_idx   <= 2'd2;
              end
              default: begin
                palette_we_out   <= 1'b1;
                palette_addr_out <= entry_cnt;
                palette_data_out <= {red_byte, green_byte, byte_in};
                byte_idx         <= 2'd0;
                if (entry_cnt != 8'd255) begin
                  entry_cnt <= entry_cnt + 8'd1;
                end
              end
            endcase
          end
        end
        IMG: begin
          if (accept) begin
            checksum       <= checksum ^ byte_in;
            image_we_out   <= 1'b1;
            image_addr_out <= pix_cnt;
            image_data_out <= byte_in;
            if (pix_cnt != AW'(NPIX - 1)) begin
              pix_cnt <= pix_cnt + AW'(1);
            end
          end
        end
        CHECK: begin
          if (accept) begin
            done_out  <= 1'b1;
            error_out <= (byte_in != checksum);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// ---------------------------------------------------------------------------
// tb_sprite_loader
//
// Directed bench for sprite_loader with a small 4x2 sprite. Stimulus pushes
// each expected RAM write onto a scoreboard queue as it drives the bytes; a
// monitor pops and compares whenever a write strobe appears.
// ---------------------------------------------------------------------------
module tb_sprite_loader;

  localparam int         W     = 4;
  localparam int         H     = 2;
  localparam int         NPIX  = W * H;
  localparam int         AW    = $clog2(NPIX);
  localparam logic [7:0] SYNCB = 8'hA5;

  logic          pixel_clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic [7:0]    byte_in;
  logic          byte_valid_in;
  logic          byte_ready_out;
  logic          palette_we_out;
  logic [7:0]    palette_addr_out;
  logic [23:0]   palette_data_out;
  logic          image_we_out;
  logic [AW-1:0] image_addr_out;
  logic [7:0]    image_data_out;
  logic          busy_out;
  logic          done_out;
  logic          error_out;

  int checks = 0;
  int passes = 0;
  int pal_count = 0;
  int img_count = 0;
  logic [63:0] exp_q[$];

  sprite_loader #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .SYNC_BYTE(SYNCB)
  ) dut (
    .pixel_clk_in    (pixel_clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .byte_in         (byte_in),
    .byte_valid_in   (byte_valid_in),
    .byte_ready_out  (byte_ready_out),
    .palette_we_out  (palette_we_out),
    .palette_addr_out(palette_addr_out),
    .palette_data_out(palette_data_out),
    .image_we_out    (image_we_out),
    .image_addr_out  (image_addr_out),
    .image_data_out  (image_data_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .error_out       (error_out)
  );

  // Free-running pixel clock, 10 time units per period.
  always #5 pixel_clk_in = ~pixel_clk_in;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // A write record is {kind, addr, data}: kind 0 = palette, 1 = image.
  function automatic logic [63:0] packWrite(input logic [7:0] kind,
                                            input logic [15:0] addr,
                                            input logic [23:0] data);
    return {16'd0, kind, addr, data};
  endfunction

  // Pop the next expected write; an empty queue means the write was not
  // expected at all, which is compared against an unreachable record.
  task automatic observeWrite(input logic [63:0] obs);
    logic [63:0] exp_w;
    if (exp_q.size() == 0) exp_w = '1;
    else exp_w = exp_q.pop_front();
    checkOutput("write_seq", obs, exp_w);
  endtask

  // Monitor: sample strobes on the falling edge, away from the active edge.
  always @(negedge pixel_clk_in) begin
    if (palette_we_out) begin
      pal_count++;
      observeWrite(packWrite(8'd0, 16'(palette_addr_out), palette_data_out));
    end
    if (image_we_out) begin
      img_count++;
      observeWrite(packWrite(8'd1, 16'(image_addr_out), 24'(image_data_out)));
    end
  end

  // Present one byte and hold it for one accepting edge, optionally preceded
  // by 0..2 idle cycles of junk with valid low.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int n_gap;
    n_gap = gaps ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < n_gap; g++) begin
      byte_valid_in = 1'b0;
      byte_in       = 8'($urandom);
      @(posedge pixel_clk_in);
      #1;
    end
    byte_in       = b;
    byte_valid_in = 1'b1;
    @(posedge pixel_clk_in);
    #1;
    byte_valid_in = 1'b0;
  endtask

  // Drive one whole packet. abort_after >= 0 stops after that pixel has been
  // written (and observed) so the caller can hit reset mid-image.
  task automatic applyStimulus(input bit corrupt, input bit gaps, input bit garbage,
                               input bit poke_start, input bit start_with_byte,
                               input int abort_after);
    logic [7:0] csum;
    logic [7:0] k8;
    logic [7:0] d;
    csum      = 8'd0;
    pal_count = 0;
    img_count = 0;

    start_in = 1'b1;
    if (start_with_byte) begin
      byte_in       = SYNCB;
      byte_valid_in = 1'b1;
    end
    @(posedge pixel_clk_in);
    #1;
    start_in      = 1'b0;
    byte_valid_in = 1'b0;
    checkOutput("busy_after_start", 64'(busy_out), 64'd1);
    checkOutput("error_cleared_on_start", 64'(error_out), 64'd0);

    if (garbage) begin
      sendByte(8'h00, gaps);
      sendByte(8'hFF, gaps);
      sendByte(8'h5A, gaps);
    end
    sendByte(SYNCB, gaps);

    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      sendByte(k8, gaps);
      sendByte(~k8, gaps);
      if (poke_start && k == 100) begin
        start_in = 1'b1;
        @(posedge pixel_clk_in);
        #1;
        start_in = 1'b0;
      end
      exp_q.push_back(packWrite(8'd0, 16'(k8), {k8, ~k8, k8 ^ 8'h55}));
      sendByte(k8 ^ 8'h55, gaps);
      csum = csum ^ k8 ^ ~k8 ^ (k8 ^ 8'h55);
    end

    for (int p = 0; p < NPIX; p++) begin
      d = 8'h10 + 8'(p);
      exp_q.push_back(packWrite(8'd1, 16'(p), 24'(d)));
      sendByte(d, gaps);
      csum = csum ^ d;
      if (p == abort_after) begin
        @(negedge pixel_clk_in);
        #1;
        return;
      end
    end

    sendByte(csum ^ (corrupt ? 8'h01 : 8'h00), gaps);
    checkOutput("done_pulse", 64'(done_out), 64'd1);
    checkOutput("error_at_done", 64'(error_out), 64'(corrupt));
    checkOutput("busy_low_at_done", 64'(busy_out), 64'd0);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("palette_write_count", 64'(pal_count), 64'd256);
    checkOutput("image_write_count", 64'(img_count), 64'(NPIX));
    @(posedge pixel_clk_in);
    #1;
    checkOutput("done_one_cycle", 64'(done_out), 64'd0);
    checkOutput("error_held", 64'(error_out), 64'(corrupt));
  endtask

  // Watchdog so the run always ends even if the DUT wedges.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_in      = 1'b0;
    start_in      = 1'b0;
    byte_in       = 8'd0;
    byte_valid_in = 1'b0;
    repeat (2) @(posedge pixel_clk_in);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_ready", 64'(byte_ready_out), 64'd0);
    checkOutput("rst_busy", 64'(busy_out), 64'd0);
    checkOutput("rst_pal_we", 64'(palette_we_out), 64'd0);
    checkOutput("rst_img_we", 64'(image_we_out), 64'd0);
    checkOutput("rst_done", 64'(done_out), 64'd0);
    checkOutput("rst_error", 64'(error_out), 64'd0);
    rst_n_in = 1'b1;
    @(posedge pixel_clk_in);
    #1;

    $display("[TB] bytes in idle without start");
    for (int i = 0; i < 4; i++) begin
      byte_in       = (i == 0) ? SYNCB : 8'(i);
      byte_valid_in = 1'b1;
      @(posedge pixel_clk_in);
      #1;
      checkOutput("idle_ready_low", 64'(byte_ready_out), 64'd0);
      checkOutput("idle_busy_low", 64'(busy_out), 64'd0);
    end
    byte_valid_in = 1'b0;

    $display("[TB] clean packet");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    $display("[TB] corrupted checksum");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (3) @(posedge pixel_clk_in);
    #1;
    checkOutput("error_held_idle", 64'(error_out), 64'd1);

    $display("[TB] garbage before sync");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);

    $display("[TB] random gaps and start pulse while busy");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1);

    $display("[TB] start with simultaneous byte, reset mid-image");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    rst_n_in = 1'b0;
    #1;
    checkOutput("midrst_img_we", 64'(image_we_out), 64'd0);
    checkOutput("midrst_img_addr", 64'(image_addr_out), 64'd0);
    checkOutput("midrst_img_data", 64'(image_data_out), 64'd0);
    checkOutput("midrst_pal_addr", 64'(palette_addr_out), 64'd0);
    checkOutput("midrst_pal_data", 64'(palette_data_out), 64'd0);
    checkOutput("midrst_busy", 64'(busy_out), 64'd0);
    checkOutput("midrst_ready", 64'(byte_ready_out), 64'd0);
    checkOutput("midrst_scoreboard", 64'(exp_q.size()), 64'd0);
    @(posedge pixel_clk_in);
    #1;
    rst_n_in = 1'b1;
    @(posedge pixel_clk_in);
    #1;

    $display("[TB] full packet after reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    repeat (2) @(posedge pixel_clk_in);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sprite_loader.md
# sprite_loader

Writer-side counterpart to the sprite display path: accepts a byte stream (e.g. from the UART receiver) and writes the 24-bit palette RAM and 8-bit indexed image RAM that the sprite renderer later reads. A framed packet carries a sync byte, 256 palette entries, WIDTH×HEIGHT pixel indices and an XOR checksum. The block sits between the byte source and the write ports of the two BRAMs, in the pixel clock domain.

## Interface
- WIDTH, 256, sprite width in pixels
- HEIGHT, 256, sprite height in pixels
- SYNC_BYTE, 8'hA5, packet start marker

Ports:
- pixel_clk_in  input  1  sole clock; all logic on rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- start_in  input  1  arm a load; sampled only in IDLE
- byte_in  input  8  stream data
- byte_valid_in  input  1  byte_in valid
- byte_ready_out  output  1  block can accept a byte
- palette_we_out  output  1  palette RAM write strobe
- palette_addr_out  output  8  palette entry index
- palette_data_out  output  24  {R,G,B}
- image_we_out  output  1  image RAM write strobe
- image_addr_out  output  $clog2(WIDTH*HEIGHT)  raster pixel address
- image_data_out  output  8  palette index
- busy_out  output  1  load in progress
- done_out  output  1  one-cycle pulse at end of load
- error_out  output  1  checksum mismatch on last load

## Operation
- States: IDLE, SYNC, PAL, IMG, CHECK.
- Byte accepted on a rising edge when byte_valid_in && byte_ready_out. byte_ready_out = 1 in SYNC/PAL/IMG/CHECK, 0 in IDLE; derived from registered state only (no combinational path from byte_valid_in).
- IDLE: start_in=1 -> SYNC; clear checksum, counters, error_out. start_in ignored in all other states.
- SYNC: accepted byte == SYNC_BYTE -> PAL; any other byte discarded, stay in SYNC. Sync byte not included in checksum.
- PAL: bytes grouped R,G,B. Byte-in-entry counter 0..2, entry counter 0..255. On third byte, write entry {R,G,B} at current entry index. After entry 255 written -> IMG.
- IMG: each accepted byte written to image address = pixel counter (0..WIDTH*HEIGHT-1, raster order). After pixel WIDTH*HEIGHT-1 -> CHECK.
- Checksum: 8-bit XOR of every accepted palette and image byte.
- CHECK: next accepted byte compared with running checksum; mismatch sets error_out. -> IDLE, done_out pulses.
- Counters never wrap within a packet; the state change occurs on the terminal count.

## Timing
- Reset (asserted anytime, async): state IDLE, all counters/checksum 0; byte_ready_out, palette_we_out, image_we_out, busy_out, done_out, error_out = 0; addr/data outputs = 0. Reset mid-load abandons the packet; RAM contents already written are left as-is.
- busy_out = (state != IDLE), registered: high the cycle after start_in is sampled, low the cycle done_out is high.
- Write strobes are registered: palette_we_out / image_we_out high exactly one cycle, the cycle after the accepting edge, with addr/data valid that same cycle. Back-to-back bytes give back-to-back strobes (one write per cycle sustained).
- Throughput: one byte per cycle, no bubbles, including the PAL->IMG and IMG->CHECK transitions.
- done_out: one cycle, the cycle after the checksum byte is accepted; error_out valid that same cycle and held until next start_in is accepted in IDLE.
- byte_valid_in low: counters and checksum hold; no strobes.
- start_in and byte_valid_in simultaneously in IDLE: the byte is not accepted (ready=0).

## Test plan
- WIDTH=4, HEIGHT=2: reset, start, send A5, palette entry k = {k, ~k, k^8'h55}, pixels 0..7 = 8'h10..8'h17, correct checksum -> 256 palette writes with addr k and matching data, 8 image writes addr 0..7 with data 10..17, done_out one pulse, error_out=0.
- Same packet with checksum byte XOR 8'h01 -> identical writes, done_out pulse, error_out=1 held until next start.
- Garbage bytes 8'h00, 8'hFF, 8'h5A before A5 -> no write strobes until after A5; load then completes correctly.
- Random byte_valid_in gaps (~50% duty) -> same write sequence as gapless run, no duplicate or missing strobes.
- Assert rst_n_in during IMG after pixel 3 -> all outputs 0 immediately; new start + full packet completes with error_out=0.
- start_in pulsed while busy, and bytes presented in IDLE without start -> ignored; byte_ready_out stays 0 in IDLE, no strobes.
